noc_port_arbiter: RTL
=====================

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one packetizer port (2..8).
REQ-002 Parameter WIDTH_PKT, default 552: stripped packet data width (518 data + 1 + 1 + 32 frame id).
REQ-003 Parameter NOC_ADDR_WIDTH, default 4: NoC destination node address width.
REQ-004 clk  in  1  single block clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_data  in  NUM_REQ x WIDTH_PKT  per-requester beat data.
REQ-007 req_dest  in  NUM_REQ x NOC_ADDR_WIDTH  per-requester destination node.
REQ-008 req_valid / req_sop / req_eop  in  NUM_REQ x 4 each  per-requester flit-slot valid, start-of-packet, end-of-packet.
REQ-009 req_ready  out  NUM_REQ  per-requester beat accept.
REQ-010 out_data / out_dest  out  WIDTH_PKT / NOC_ADDR_WIDTH  beat and destination to the packetizer.
REQ-011 out_valid / out_sop / out_eop  out  4 each  flit-slot valid, sop, eop to the packetizer.
REQ-012 out_ready  in  1  packetizer ready.

Function
REQ-013 A requester presents a beat when any bit of its req_valid is set; it presents a head beat when that beat also has any req_sop bit set; it presents a tail beat when that beat has any req_eop bit set.
REQ-014 A beat is accepted in a cycle where the requester presents it and its req_ready is high.
REQ-015 The FSM has two states: IDLE (no owner) and LOCKED (one owner).
REQ-016 In IDLE, the winner is the first requester, searching upward from rr_ptr with wrap-around, that presents a head beat; on the next edge the FSM enters LOCKED with owner = winner.
REQ-017 In IDLE, all req_ready bits are low, and a requester that presents a beat without a head is never selected.
REQ-018 In LOCKED, req_ready[owner] = !out_valid_any | out_ready, and every other req_ready bit is low.
REQ-019 The output stage is a single register; an accepted beat (data, dest, valid, sop, eop) appears on the outputs exactly 1 cycle after acceptance.
REQ-020 The output register holds its value while any out_valid bit is set and out_ready is low.
REQ-021 The output valid bits clear when out_ready is high and no beat is accepted that cycle.
REQ-022 On acceptance of a tail beat, including a beat that is both head and tail, the FSM returns to IDLE and rr_ptr becomes (owner+1) mod NUM_REQ.
REQ-023 Minimum turnaround is one IDLE cycle between packets, so a back-to-back single-beat packet from the same port sees a 1-cycle bubble.
REQ-024 A head beat presented by the owner while LOCKED is forwarded unchanged, with no re-arbitration.
REQ-025 Packets from different requesters never interleave at the output.

Reset
REQ-026 While rst_n is low: FSM = IDLE, owner = 0, rr_ptr = 0, and out_valid/out_sop/out_eop = 0; out_data and out_dest have undefined values.
REQ-027 While rst_n is low, all req_ready bits are 0.
REQ-028 Reset asserted mid-packet abandons the packet; after release the arbiter starts in IDLE and only accepts a fresh head beat.

Configuration
REQ-029 Macro NOC_ARB_STATS_EN, when defined, adds outputs pkt_count[31:0] and orphan_count[15:0].
REQ-030 pkt_count increments on each accepted tail beat.
REQ-031 orphan_count increments once per cycle in IDLE in which at least one requester presents a beat without a head.
REQ-032 Both counters saturate at all-ones and clear on reset.
REQ-033 When NOC_ARB_STATS_EN is undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-034 Contention: requesters 0 and 2 each present a 3-beat packet at cycle 0, out_ready held 1 -> the packet from requester 0 is on the output at cycles 2-4 and the packet from requester 2 at cycles 6-8, rr_ptr = 3 at the end.
REQ-035 Fairness: all 4 requesters present continuous 1-beat packets for 40 cycles -> grant order is 0,1,2,3,0,... and each requester forwards 5 packets.
REQ-036 Backpressure: out_ready = 0 for 5 cycles during the middle beat of a 4-beat packet -> the outputs are stable for those cycles, no beat is lost or duplicated, and req_ready[owner] is low throughout.
REQ-037 Orphan beat: requester 1 presents valid = 4'b1111 with sop = 0 while in IDLE for 3 cycles -> no grant to requester 1, req_ready = 0, and orphan_count = 3 when NOC_ARB_STATS_EN is defined.
REQ-038 Reset mid-packet: rst_n driven low after beat 2 of 4 -> out_valid = 0 immediately, FSM is in IDLE after release, and the next accepted beat has sop set.

Source files
------------

// File: rtl/noc_port_arbiter.sv
// Packet-locked round-robin arbiter: NUM_REQ requesters share one packetizer port through a single output register.
// Optional build macro NOC_ARB_STATS_EN adds the pkt_count / orphan_count statistics outputs.
module noc_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_PKT      = 552,
  parameter int NOC_ADDR_WIDTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0][WIDTH_PKT-1:0]       req_data,
  input  logic [NUM_REQ-1:0][NOC_ADDR_WIDTH-1:0]  req_dest,
  input  logic [NUM_REQ-1:0][3:0]                 req_valid,
  input  logic [NUM_REQ-1:0][3:0]                 req_sop,
  input  logic [NUM_REQ-1:0][3:0]                 req_eop,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [WIDTH_PKT-1:0]                    out_data,
  output logic [NOC_ADDR_WIDTH-1:0]               out_dest,
  output logic [3:0]                              out_valid,
  output logic [3:0]                              out_sop,
  output logic [3:0]                              out_eop,
  input  logic                                    out_ready
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [31:0]                             pkt_count,
  output logic [15:0]                             orphan_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] present;
  logic [NUM_REQ-1:0] head;
  logic [NUM_REQ-1:0] tail;
  logic               accept;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      present[i] = |req_valid[i];
      head[i]    = present[i] & (|req_sop[i]);
      tail[i]    = present[i] & (|req_eop[i]);
    end
  end

  // Round-robin pick: lowest head at or above rr_ptr, otherwise lowest head overall (the wrap).
  always_comb begin
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] any_idx;
    logic             hi_found;
    hi_idx   = '0;
    any_idx  = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (head[i]) begin
        any_idx = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : any_idx;
  end

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED) req_ready[owner] = ~(|out_valid) | out_ready;
  end

  assign accept   = (state == LOCKED) & present[owner] & req_ready[owner];
  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|head) begin
            state <= LOCKED;
            owner <= winner;
          end
        end
        LOCKED: begin
          if (accept && tail[owner]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat qualifiers are reset so nothing downstream sees a phantom beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_sop   <= '0;
      out_eop   <= '0;
    end else if (accept) begin
      out_valid <= req_valid[owner];
      out_sop   <= req_sop[owner];
      out_eop   <= req_eop[owner];
    end else if (out_ready) begin
      out_valid <= '0;
      out_sop   <= '0;
      out_eop   <= '0;
    end
  end

  // NOTE: the wide payload register has no reset; it is only meaningful while out_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= req_data[owner];
      out_dest <= req_dest[owner];
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [NUM_REQ-1:0] orphan;

  assign orphan = present & ~head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count    <= '0;
      orphan_count <= '0;
    end else begin
      if (accept && tail[owner] && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
      if ((state == IDLE) && (|orphan) && (orphan_count != '1)) orphan_count <= orphan_count + 1'b1;
    end
  end
`endif

endmodule
